// File: rtl/axi4_lite_master_arbiter.sv
// axi4_lite_master_arbiter: round-robin sharing of one AXI4-Lite master port between two single-beat requesters
//   iCLK/iRST          : clock, asynchronous active-high reset
//   req_* / rsp_*      : per-requester command accept and completion pulses, shared response data
//   m_AW*/m_W*/m_B*    : AXI4-Lite write channels, one transaction at a time
//   m_AR*/m_R*         : AXI4-Lite read channels
module axi4_lite_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [1:0]                  req_VALID,
  input  logic [1:0]                  req_WRITE,
  input  logic [2*ADDR_WIDTH-1:0]     req_ADDR,
  input  logic [2*DATA_WIDTH-1:0]     req_WDATA,
  input  logic [2*(DATA_WIDTH/8)-1:0] req_WSTRB,
  output logic [1:0]                  req_READY,
  output logic [1:0]                  rsp_VALID,
  output logic [DATA_WIDTH-1:0]       rsp_RDATA,
  output logic [1:0]                  rsp_RESP,
  output logic [ADDR_WIDTH-1:0]       m_AWADDR,
  output logic [2:0]                  m_AWPROT,
  output logic                        m_AWVALID,
  input  logic                        m_AWREADY,
  output logic [DATA_WIDTH-1:0]       m_WDATA,
  output logic [DATA_WIDTH/8-1:0]     m_WSTRB,
  output logic                        m_WVALID,
  input  logic                        m_WREADY,
  input  logic                        m_BVALID,
  input  logic [1:0]                  m_BRESP,
  output logic                        m_BREADY,
  output logic [ADDR_WIDTH-1:0]       m_ARADDR,
  output logic [2:0]                  m_ARPROT,
  output logic                        m_ARVALID,
  input  logic                        m_ARREADY,
  input  logic                        m_RVALID,
  input  logic [1:0]                  m_RRESP,
  input  logic [DATA_WIDTH-1:0]       m_RDATA,
  output logic                        m_RREADY
);
  localparam int SW = DATA_WIDTH/8;
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_grant_q, last_grant_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0] resp_q, resp_d, rsp_valid_q, rsp_valid_d;
  logic grant, accept;
  // on a tie the requester that did not win last time is chosen
  assign grant  = (&req_VALID) ? ~last_grant_q : req_VALID[1];
  assign accept = (state_q == IDLE) && (|req_VALID);
  assign req_READY = (accept && !iRST) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign m_AWVALID = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign m_WVALID  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign m_BREADY  = (state_q == WR_RESP);
  assign m_ARVALID = (state_q == RD_ADDR);
  assign m_RREADY  = (state_q == RD_DATA);
  assign m_AWADDR  = addr_q;
  assign m_ARADDR  = addr_q;
  assign m_WDATA   = wdata_q;
  assign m_WSTRB   = wstrb_q;
  assign m_AWPROT  = PROT;
  assign m_ARPROT  = PROT;
  assign rsp_VALID = rsp_valid_q;
  assign rsp_RDATA = rdata_q;
  assign rsp_RESP  = resp_q;
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    rsp_valid_d  = 2'b00;
    aw_done_d    = aw_done_q | (m_AWVALID & m_AWREADY);
    w_done_d     = w_done_q | (m_WVALID & m_WREADY);
    unique case (state_q)
      IDLE: if (accept) begin
        owner_d      = grant;
        last_grant_d = grant;
        addr_d       = grant ? req_ADDR[ADDR_WIDTH +: ADDR_WIDTH] : req_ADDR[0 +: ADDR_WIDTH];
        wdata_d      = grant ? req_WDATA[DATA_WIDTH +: DATA_WIDTH] : req_WDATA[0 +: DATA_WIDTH];
        wstrb_d      = grant ? req_WSTRB[SW +: SW] : req_WSTRB[0 +: SW];
        aw_done_d    = 1'b0;
        w_done_d     = 1'b0;
        state_d      = req_WRITE[grant] ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: state_d = (aw_done_d && w_done_d) ? WR_RESP : WR_ADDR_DATA;
      WR_RESP: if (m_BVALID) begin
        resp_d      = m_BRESP;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = IDLE;
      end
      RD_ADDR: state_d = m_ARREADY ? RD_DATA : RD_ADDR;
      RD_DATA: if (m_RVALID) begin
        rdata_d     = m_RDATA;
        resp_d      = m_RRESP;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end
endmodule

// File: doc/axi4_lite_master_arbiter.md
Name: axi4_lite_master_arbiter

Overview:
- Shares one AXI4-Lite master port between 2 local requesters, each using a simple single-beat command/response interface.
- Round-robin arbitration; one outstanding transaction at a time.
- Sequences AW/W/B for writes and AR/R for reads.
- Sits between client logic and dut_axi4_lite_master_wrapper-style master channels.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width. WSTRB width is DATA_WIDTH/8.
- PROT, 3'b000, constant value driven on m_AWPROT and m_ARPROT.

Ports:
- iCLK  in  1  clock, all state on rising edge
- iRST  in  1  asynchronous active-high reset
- req_VALID  in  2  per-requester command valid; bit i = requester i
- req_WRITE  in  2  1 = write, 0 = read
- req_ADDR  in  2*ADDR_WIDTH  slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_WDATA  in  2*DATA_WIDTH  write data per requester
- req_WSTRB  in  2*DATA_WIDTH/8  write strobes per requester
- req_READY  out  2  one-cycle command-accept pulse to the granted requester
- rsp_VALID  out  2  one-cycle completion pulse to the owning requester
- rsp_RDATA  out  DATA_WIDTH  read data of the last completed read
- rsp_RESP  out  2  BRESP/RRESP of the last completed transaction
- m_AWADDR out ADDR_WIDTH; m_AWPROT out 3; m_AWVALID out 1; m_AWREADY in 1
- m_WDATA out DATA_WIDTH; m_WSTRB out DATA_WIDTH/8; m_WVALID out 1; m_WREADY in 1
- m_BVALID in 1; m_BRESP in 2; m_BREADY out 1
- m_ARADDR out ADDR_WIDTH; m_ARPROT out 3; m_ARVALID out 1; m_ARREADY in 1
- m_RVALID in 1; m_RRESP in 2; m_RDATA in DATA_WIDTH; m_RREADY out 1

Behaviour:
- Reset (asynchronous, while iRST=1):
  - FSM goes to IDLE.
  - All VALID/READY outputs are 0; address, data, strobe, rsp_RDATA and rsp_RESP are 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Reset mid-transaction aborts the transaction. No rsp_VALID is issued and AXI valids drop immediately.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - If any req_VALID is set, grant one requester. If only one is valid, grant it. If both are valid, grant the one not equal to last_grant.
  - In the same cycle, pulse req_READY[g] and latch owner, ADDR, WDATA, WSTRB and WRITE; update last_grant = g.
  - Next state is WR_ADDR_DATA if WRITE, else RD_ADDR.
  - req_READY is never asserted outside IDLE.
  - Latency: AXI valid(s) go high on the first cycle after the accept.
- WR_ADDR_DATA:
  - m_AWVALID and m_WVALID rise together.
  - Each drops independently on the cycle after its own VALID&READY handshake. An aw_done/w_done flag records each handshake.
  - A handshake in the first cycle is legal (READY already high).
  - Exit to WR_RESP once both handshakes are done, including when both complete in the same cycle.
  - Address, data and strobes stay stable while the corresponding VALID is high.
- WR_RESP:
  - m_BREADY = 1.
  - On m_BVALID: latch rsp_RESP = m_BRESP, pulse rsp_VALID[owner] on the next cycle, return to IDLE. rsp_RDATA is unchanged.
- RD_ADDR:
  - m_ARVALID = 1 until m_ARREADY is seen.
  - Then go to RD_DATA; ARVALID is 0 from the next cycle.
- RD_DATA:
  - m_RREADY = 1.
  - On m_RVALID: latch rsp_RDATA = m_RDATA and rsp_RESP = m_RRESP, pulse rsp_VALID[owner], return to IDLE.
- rsp_VALID pulse:
  - Occurs in the cycle the FSM re-enters IDLE.
  - A new grant may occur in that same IDLE cycle, so back-to-back issue costs one cycle.
  - rsp_RDATA and rsp_RESP hold until the next completion.
- req_VALID dropping after accept has no effect. A non-granted request stays pending; the requester must hold it.
- Slave error responses (SLVERR, DECERR) are passed through unchanged. There are no retries and no timeout.
- AWPROT and ARPROT are always PROT.

Test Plan:
- Req0 write, ADDR=0x10, WDATA=0xDEADBEEF, WSTRB=0xF; slave READYs held high and BVALID 1 cycle later with OKAY:
  - req_READY[0] pulses.
  - AW and W handshake on the next cycle with correct values.
  - rsp_VALID[0] pulses with rsp_RESP=0.
- Req1 read, ADDR=0x24; ARREADY delayed 3 cycles; RDATA=0x12345678, RRESP=2'b10:
  - ARVALID is held for 4 cycles with a stable address.
  - rsp_VALID[1] pulses with rsp_RDATA=0x12345678 and rsp_RESP=2'b10.
- Write with AWREADY in cycle 1 and WREADY in cycle 4:
  - AWVALID drops after cycle 1; WVALID is held until cycle 4.
  - BREADY does not assert before the W handshake.
- Both req_VALID held high continuously for 4 transactions after reset:
  - Grant order is 0, 1, 0, 1.
  - Exactly one rsp_VALID pulse per grant, each to the matching requester.
- iRST asserted during WR_RESP:
  - All outputs go to 0 immediately; no rsp_VALID is issued.
  - After release with both requesting, requester 0 is granted first.
